digilock_core: RTL
==================

// Module: digilock_core
// PURPOSE
//  Parametrised lock controller FSM, successor to the fixed 4-digit lock ASM. Takes single-cycle
//  debounced button pulses plus a switch digit and collects an N-digit code. Compares the code
//  against a stored code, counts failed tries and enforces a timed lockout. Supports changing the
//  code with confirm re-entry. Drives status LEDs and a packed display bus for the SSD driver.
// PARAMETERS
//  DIGIT_W      4        bits per digit (switch width)
//  NUM_DIGITS   4        digits per code, >=1
//  MAX_TRIES    3        consecutive wrong codes before lockout, >=1
//  LOCKOUT_CYC  1000     lockout duration in clk cycles, >=1
//  DEFAULT_CODE 0        reset code, NUM_DIGITS*DIGIT_W bits, first digit in MSBs
// PORTS
//  clk          in   1                  system (slow) clock, rising edge
//  rst          in   1                  async active-high reset
//  clear_p      in   1                  clear pulse, 1 cycle, debounced
//  enter_p      in   1                  enter pulse, 1 cycle, debounced
//  change_p     in   1                  change-code pulse, 1 cycle, debounced
//  digit_in     in   DIGIT_W            switch value, sampled on enter_p
//  led          out  3                  [0] locked, [1] unlocked, [2] error
//  disp         out  NUM_DIGITS*DIGIT_W entry buffer, first entered digit in MSBs
//  disp_blank   out  NUM_DIGITS         1 = digit position blank (bit NUM_DIGITS-1 = first digit)
//  tries_left   out  $clog2(MAX_TRIES+1) remaining tries
//  state_o      out  3                  LOCKED=0 UNLOCKED=1 NEWCODE=2 CONFIRM=3 LOCKOUT=4
// BEHAVIOUR
//  Reset (async): state LOCKED, code=DEFAULT_CODE, buffer=0, count=0, tries_left=MAX_TRIES,
//   err=0, timer=0. led=3'b001, disp=0, disp_blank=all 1.
//  Pulse priority in one cycle: clear_p > change_p > enter_p; lower-priority pulses are dropped.
//  Entry (LOCKED/NEWCODE/CONFIRM): enter_p stores digit_in at position count; count++.
//   An enter that makes count==NUM_DIGITS completes entry. The candidate is the buffer including
//   that digit. The decision takes effect on the next edge (1-cycle latency). Buffer and count
//   return to 0 on that edge.
//  LOCKED: complete & match -> UNLOCKED, tries_left=MAX_TRIES.
//   Complete & mismatch -> err=1, tries_left--. If tries_left was 1 -> LOCKOUT, timer=LOCKOUT_CYC-1.
//   clear_p -> buffer/count=0, stay. change_p ignored.
//  LOCKOUT: all pulses ignored; timer decrements each cycle. On the cycle timer==0 -> LOCKED,
//   tries_left=MAX_TRIES, err=0. Total dwell is exactly LOCKOUT_CYC cycles.
//  UNLOCKED: clear_p -> LOCKED (relock). change_p -> NEWCODE. enter_p ignored.
//  NEWCODE: complete -> pending=candidate, CONFIRM. clear_p -> abort to UNLOCKED, code unchanged.
//  CONFIRM: complete & candidate==pending -> code=pending, UNLOCKED.
//   Mismatch -> UNLOCKED, code unchanged, err=1. clear_p -> abort to UNLOCKED.
//  err: cleared by any accepted pulse in the cycle after it is set. Forced 1 in LOCKOUT.
//  led[0]=state in {LOCKED,LOCKOUT}; led[1]=state in {UNLOCKED,NEWCODE,CONFIRM}; led[2]=err.
//  disp_blank[NUM_DIGITS-1-i]=(i>=count) in entry states; all 1 in UNLOCKED/LOCKOUT.
//  disp always shows the buffer. Unfilled digits are 0.
//  All DIGIT_W values are legal digits (no decimal restriction). Outputs are registered.
//  Reset mid-entry or mid-lockout: immediate return to the reset state; pending code discarded.
// TESTING
//  Defaults. Reset, enter 0,0,0,0 -> state_o=1, led=3'b010, tries_left=3, 1 cycle after 4th enter.
//  Enter 1,2,3,4 three times -> tries_left 2,1, then LOCKOUT.
//   led=3'b101 for exactly 1000 cycles, then LOCKED with tries_left=3.
//  Unlock, change_p, enter 9,8,7,6 twice -> UNLOCKED. clear_p relocks.
//   0,0,0,0 fails; 9,8,7,6 unlocks.
//  Unlock, change_p, 1,1,1,1 then 2,2,2,2 -> UNLOCKED, led[2]=1, code still 0000.
//  Enter 5,5 then clear_p+enter_p in the same cycle -> count=0, disp_blank=4'b1111, digit dropped.
//  Assert rst during LOCKOUT at cycle 500 -> state_o=0, tries_left=3, led=3'b001 immediately.

Source files
------------

// File: rtl/digilock_core.sv
// Lock controller: collects an N-digit code from debounced pulses. It checks the code against a
// stored code, enforces a timed lockout after repeated failures and supports code change with confirm.
module digilock_core #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_TRIES    = 3,
  parameter int LOCKOUT_CYC  = 1000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_p,
  input  logic                              enter_p,
  input  logic                              change_p,
  input  logic [DIGIT_W-1:0]                digit_in,
  output logic [2:0]                        led,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     disp,
  output logic [NUM_DIGITS-1:0]             disp_blank,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left,
  output logic [2:0]                        state_o
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_UNLOCKED = 3'd1,
    S_NEWCODE  = 3'd2,
    S_CONFIRM  = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  state_t                r_state,   w_state_next;
  logic [CODE_W-1:0]     r_code,    w_code_next;
  logic [CODE_W-1:0]     r_pend,    w_pend_next;
  logic [CODE_W-1:0]     r_buf,     w_buf_next;
  logic [CNT_W-1:0]      r_count,   w_count_next;
  logic [TRY_W-1:0]      r_tries,   w_tries_next;
  logic                  r_err,     w_err_next;
  logic [TMR_W-1:0]      r_timer,   w_timer_next;
  logic [2:0]            r_led,     w_led_next;
  logic [NUM_DIGITS-1:0] r_blank,   w_blank_next;

  logic w_clr;
  logic w_chg;
  logic w_ent;
  logic w_complete;
  logic w_entry_next;

  // Writes one digit into the buffer slot selected by the entry count (first digit in MSBs).
  function automatic logic [CODE_W-1:0] store_digit(
    input logic [CODE_W-1:0]  buf_in,
    input logic [CNT_W-1:0]   pos,
    input logic [DIGIT_W-1:0] dig
  );
    logic [CODE_W-1:0] res;
    res = buf_in;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos == CNT_W'(i)) begin
        res[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = dig;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_clr      = clear_p;
  assign w_chg      = change_p & ~clear_p;
  assign w_ent      = enter_p & ~clear_p & ~change_p;
  assign w_complete = (r_count == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOCKED;
      r_code  <= DEFAULT_CODE;
      r_pend  <= '0;
      r_buf   <= '0;
      r_count <= '0;
      r_tries <= TRY_MAX;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_led   <= 3'b001;
      r_blank <= '1;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_pend  <= w_pend_next;
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      r_tries <= w_tries_next;
      r_err   <= w_err_next;
      r_timer <= w_timer_next;
      r_led   <= w_led_next;
      r_blank <= w_blank_next;
    end
  end

  // A completed entry is decided in the cycle after the last digit, and pulses in that cycle are dropped.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_pend_next  = r_pend;
    w_buf_next   = r_buf;
    w_count_next = r_count;
    w_tries_next = r_tries;
    w_err_next   = r_err;
    w_timer_next = r_timer;
    case (r_state)
      S_LOCKED: begin
        if (w_complete) begin
          w_buf_next   = '0;
          w_count_next = '0;
          if (r_buf == r_code) begin
            w_state_next = S_UNLOCKED;
            w_tries_next = TRY_MAX;
          end else begin
            w_err_next   = 1'b1;
            w_tries_next = r_tries - TRY_ONE;
            if (r_tries == TRY_ONE) begin
              w_state_next = S_LOCKOUT;
              w_timer_next = TMR_INIT;
            end else begin
              w_state_next = S_LOCKED;
            end
          end
        end else if (w_clr) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_err_next   = 1'b0;
        end else if (w_ent) begin
          w_buf_next   = store_digit(r_buf, r_count, digit_in);
          w_count_next = r_count + CNT_ONE;
          w_err_next   = 1'b0;
        end else begin
          w_state_next = S_LOCKED;
        end
      end
      S_UNLOCKED: begin
        if (w_clr) begin
          w_state_next = S_LOCKED;
          w_err_next   = 1'b0;
        end else if (w_chg) begin
          w_state_next = S_NEWCODE;
          w_err_next   = 1'b0;
        end else begin
          w_state_next = S_UNLOCKED;
        end
      end
      S_NEWCODE, S_CONFIRM: begin
        if (w_complete) begin
          w_buf_next   = '0;
          w_count_next = '0;
          if (r_state == S_NEWCODE) begin
            w_pend_next  = r_buf;
            w_state_next = S_CONFIRM;
          end else if (r_buf == r_pend) begin
            w_code_next  = r_pend;
            w_state_next = S_UNLOCKED;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_UNLOCKED;
          end
        end else if (w_clr) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_err_next   = 1'b0;
          w_state_next = S_UNLOCKED;
        end else if (w_ent) begin
          w_buf_next   = store_digit(r_buf, r_count, digit_in);
          w_count_next = r_count + CNT_ONE;
          w_err_next   = 1'b0;
        end else begin
          w_state_next = r_state;
        end
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_next = S_LOCKED;
          w_tries_next = TRY_MAX;
          w_err_next   = 1'b0;
        end else begin
          w_timer_next = r_timer - TMR_ONE;
          w_err_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = S_LOCKED;
        w_buf_next   = '0;
        w_count_next = '0;
        w_tries_next = TRY_MAX;
        w_err_next   = 1'b0;
      end
    endcase
  end

  // Status outputs are derived from next-state values so they line up with the registered state.
  always_comb begin
    w_entry_next = (w_state_next == S_LOCKED) || (w_state_next == S_NEWCODE) ||
                   (w_state_next == S_CONFIRM);
    w_led_next[0] = (w_state_next == S_LOCKED) || (w_state_next == S_LOCKOUT);
    w_led_next[1] = (w_state_next == S_UNLOCKED) || (w_state_next == S_NEWCODE) ||
                    (w_state_next == S_CONFIRM);
    w_led_next[2] = w_err_next;
    w_blank_next  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_entry_next) begin
        w_blank_next[NUM_DIGITS-1-i] = (CNT_W'(i) >= w_count_next);
      end else begin
        w_blank_next[NUM_DIGITS-1-i] = 1'b1;
      end
    end
  end

  assign led        = r_led;
  assign disp       = r_buf;
  assign disp_blank = r_blank;
  assign tries_left = r_tries;
  assign state_o    = r_state;

endmodule
